cla_accumulator: RTL and testbench
==================================

CLA_ACCUMULATOR -- requirements
Module: cla_accumulator

Interface
REQ-001 The block SHALL use the parameter MAX_COUNT, default 255, as the number of accepted operands that forces a burst to end (legal range 1..255).
REQ-002 Port clk SHALL be an input, 1 bit wide, and serve as the single rising-edge clock.
REQ-003 Port rst_n SHALL be an input, 1 bit wide; reset is synchronous and active-low.
REQ-004 Port clr SHALL be an input, 1 bit wide, and act as a synchronous burst abort.
REQ-005 Port in_valid SHALL be an input, 1 bit wide, and indicate that an operand is offered.
REQ-006 Port in_ready SHALL be an output, 1 bit wide, and indicate that an operand is accepted.
REQ-007 Port in_data SHALL be an input, 32 bits wide, and carry the operand.
REQ-008 Port in_last SHALL be an input, 1 bit wide, and mark the final operand of a burst.
REQ-009 Port out_valid SHALL be an output, 1 bit wide, and indicate that a result is presented.
REQ-010 Port out_ready SHALL be an input, 1 bit wide, and indicate that the consumer accepts the result.
REQ-011 Port out_sum SHALL be an output, 32 bits wide, and carry the accumulated sum modulo 2^32.
REQ-012 Port out_ovf SHALL be an output, 1 bit wide, and carry the sticky carry-out of any addition in the burst.
REQ-013 Port out_count SHALL be an output, 8 bits wide, and carry the number of operands accepted in the burst.

Function
REQ-014 The block SHALL implement FSM states ACC (accepting operands) and HOLD (presenting the result).
REQ-015 in_ready SHALL equal (state==ACC) && !clr && rst_n, combinationally.
REQ-016 An input handshake SHALL occur when in_valid && in_ready are both high on a clk edge.
REQ-017 On each input handshake, acc SHALL load sum[31:0] of the 32-bit CLA add of acc and in_data with cin=0, ovf SHALL load ovf | sum[32], and count SHALL increment by 1.
REQ-018 On a handshake where in_last==1 or count+1==MAX_COUNT, the FSM SHALL move ACC->HOLD, so out_valid rises exactly 1 cycle after the final beat.
REQ-019 out_valid SHALL equal (state==HOLD); out_sum, out_ovf and out_count SHALL be driven directly from the acc, ovf and count registers and held stable throughout HOLD.
REQ-020 In HOLD, when out_ready==1, the FSM SHALL move to ACC and clear acc, ovf and count to 0; in_ready is therefore high the following cycle.
REQ-021 In HOLD with out_ready==0, the block SHALL keep all state, and in_valid SHALL be ignored (backpressure).
REQ-022 clr==1 in any state SHALL force state ACC and clear acc, ovf and count to 0 on the next edge; clr SHALL take priority over both input and output handshakes, and a pending result is discarded.
REQ-023 in_last SHALL be ignored when no handshake occurs.
REQ-024 A single-operand burst SHALL yield out_sum=in_data, out_count=1, out_ovf=0.

Reset
REQ-025 On a rst_n==0 edge, the block SHALL set state=ACC, acc=0, ovf=0 and count=0, giving out_valid=0, out_sum=0, out_ovf=0 and out_count=0 on the next cycle.
REQ-026 Reset SHALL override clr and all handshakes, including when asserted mid-burst or during HOLD.
REQ-027 in_ready SHALL be 0 while rst_n==0.

Structure
REQ-028 Package cla_pkg SHALL hold DATA_W=32, CNT_W=8 and the state enum {ACC, HOLD}.
REQ-029 The adder SHALL be a single instance of the existing sub-module carry_look_ahead_32_4bit (a=acc, b=in_data, cin=0).
REQ-030 The adder SHALL be purely combinational, with all state registered in cla_accumulator; no behavioural '+' operator SHALL be used on the data path.

Verification
REQ-031 Operands 1, 2, 3 with in_last on 3 SHALL produce, one cycle later, out_valid=1, out_sum=6, out_ovf=0, out_count=3.
REQ-032 Operands 0xFFFFFFFF then 0x00000002 (last) SHALL produce out_sum=0x00000001, out_ovf=1, out_count=2.
REQ-033 With out_ready held 0 for 5 cycles and in_valid held 1, the bench SHALL observe in_ready=0 and a stable result; after out_ready=1, in_ready=1 on the next cycle, and the next burst starts from 0.
REQ-034 With MAX_COUNT=4 and five operands of 1 with no last, the first result SHALL be out_sum=4, out_count=4, and the fifth operand SHALL be accepted as the first beat of a new burst.
REQ-035 Asserting clr after 2 operands, then sending 7 (last), SHALL produce no out_valid for the aborted burst and a result out_sum=7, out_count=1.
REQ-036 Asserting rst_n=0 for one edge during HOLD SHALL give out_valid=0 and out_sum=0 on the next cycle, and in_ready=1 once rst_n=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared widths and FSM state encoding for the CLA accumulator slice.
package cla_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/carry_look_ahead_32_4bit.sv
// Purely combinational 32-bit adder built from eight 4-bit carry-lookahead groups.
module carry_look_ahead_32_4bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [32:0] sum
);

  // Group carries ripple between 4-bit blocks; inside a block every carry is
  // formed directly from generate/propagate terms and the block carry-in.
  function automatic logic [32:0] cla_add(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        ci);
    logic [31:0] s;
    logic        c;
    logic [3:0]  g;
    logic [3:0]  p;
    logic        c1;
    logic        c2;
    logic        c3;
    logic        c4;
    s = '0;
    c = ci;
    for (int k = 0; k < 8; k++) begin
      g  = x[4*k +: 4] & y[4*k +: 4];
      p  = x[4*k +: 4] ^ y[4*k +: 4];
      c1 = g[0] | (p[0] & c);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (&p[2:0] & c);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (&p & c);
      s[4*k +: 4] = p ^ {c3, c2, c1, c};
      c = c4;
    end
    return {c, s};
  endfunction

  assign sum = cla_add(a, b, cin);

endmodule

// File: rtl/cla_accumulator.sv
// Burst accumulator: sums operands through a CLA adder, then holds the result
// with a sticky carry flag and beat count until the consumer takes it.
module cla_accumulator
  import cla_pkg::*;
#(
  parameter int MAX_COUNT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W:0]    add_sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic               in_hs;

  carry_look_ahead_32_4bit u_cla (
    .a   (acc_q),
    .b   (in_data),
    .cin (1'b0),
    .sum (add_sum)
  );

  assign in_ready  = (state_q == ACC) && !clr && rst_n;
  assign in_hs     = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

  // clr outranks both handshakes; in HOLD without out_ready everything holds.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else if (state_q == ACC) begin
      if (in_hs) begin
        acc_d = add_sum[DATA_W-1:0];
        ovf_d = ovf_q | add_sum[DATA_W];
        cnt_d = cnt_inc;
        if (in_last || (cnt_inc == MAX_C)) begin
          state_d = HOLD;
        end
      end
    end else if (out_ready) begin
      state_d = ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cla_accumulator.sv
// Directed bench for cla_accumulator built with a burst limit of 4 beats.
module tb_cla_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_count;

  int errors = 0;
  int checks = 0;

  cla_accumulator #(.MAX_COUNT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] s,
                               input logic o, input logic [7:0] c);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".sum"},   out_sum, s);
    chk({tag, ".ovf"},   {31'b0, out_ovf}, {31'b0, o});
    chk({tag, ".count"}, {24'b0, out_count}, {24'b0, c});
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain.valid", {31'b0, out_valid}, 32'd0);
    chk("drain.sum",   out_sum, 32'd0);
    chk("drain.rdy",   {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst.valid",    {31'b0, out_valid}, 32'd0);
    chk("rst.sum",      out_sum, 32'd0);
    chk("rst.count",    {24'b0, out_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", {31'b0, in_ready}, 32'd1);

    // 1 + 2 + 3, last on 3
    beat(32'd1, 1'b0);
    beat(32'd2, 1'b0);
    chk("b123.mid_valid", {31'b0, out_valid}, 32'd0);
    chk("b123.mid_count", {24'b0, out_count}, 32'd2);
    beat(32'd3, 1'b1);
    expect_result("b123", 32'd6, 1'b0, 8'd3);
    chk("b123.in_ready", {31'b0, in_ready}, 32'd0);
    drain();

    // carry out of the final add
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'h0000_0002, 1'b1);
    expect_result("wrap", 32'h0000_0001, 1'b1, 8'd2);
    drain();

    // carry flag stays set after a later carry-free add
    beat(32'h8000_0000, 1'b0);
    beat(32'h8000_0000, 1'b0);
    beat(32'd5, 1'b1);
    expect_result("sticky", 32'd5, 1'b1, 8'd3);
    drain();

    // backpressure with in_valid held high
    beat(32'd10, 1'b0);
    beat(32'd20, 1'b1);
    in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp.sum",      out_sum, 32'd30);
      chk("bp.count",    {24'b0, out_count}, 32'd2);
      chk("bp.valid",    {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.rel_ready", {31'b0, in_ready}, 32'd1);
    chk("bp.rel_sum",   out_sum, 32'd0);
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    expect_result("single", 32'd99, 1'b0, 8'd1);
    drain();

    // burst limit of 4 with no last
    for (int i = 0; i < 4; i++) beat(32'd1, 1'b0);
    expect_result("max", 32'd4, 1'b0, 8'd4);
    in_valid = 1'b1; in_data = 32'd1;
    tick();
    expect_result("max.hold", 32'd4, 1'b0, 8'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("max.rel_count", {24'b0, out_count}, 32'd0);
    tick();
    in_valid = 1'b0; in_data = '0;
    chk("max.fifth_valid", {31'b0, out_valid}, 32'd0);
    chk("max.fifth_sum",   out_sum, 32'd1);
    chk("max.fifth_count", {24'b0, out_count}, 32'd1);

    // in_last without in_valid is not a beat
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    chk("lastnv.valid", {31'b0, out_valid}, 32'd0);
    chk("lastnv.count", {24'b0, out_count}, 32'd1);

    // abort via clr, competing with an offered last beat
    beat(32'd5, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'd100; in_last = 1'b1;
    #1;
    chk("clr.in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    chk("clr.valid", {31'b0, out_valid}, 32'd0);
    chk("clr.sum",   out_sum, 32'd0);
    chk("clr.count", {24'b0, out_count}, 32'd0);
    beat(32'd7, 1'b1);
    expect_result("clr.after", 32'd7, 1'b0, 8'd1);

    // clr in HOLD discards the pending result
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrhold.valid", {31'b0, out_valid}, 32'd0);
    chk("clrhold.sum",   out_sum, 32'd0);
    beat(32'd8, 1'b1);
    expect_result("pre_rst", 32'd8, 1'b0, 8'd1);

    // reset during HOLD, with out_ready and clr idle
    rst_n = 1'b0;
    #1;
    chk("rsthold.in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("rsthold.valid", {31'b0, out_valid}, 32'd0);
    chk("rsthold.sum",   out_sum, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rsthold.rel_ready", {31'b0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
